// File: rtl/vc_pkg.sv
// rtl/vc_pkg.sv - shared defaults and types for the victim cache
// Holds the default geometry used by victim_cache_param and vc_lru, plus the
// age-update command passed from the lookup logic to the replacement tracker.
package vc_pkg;

    localparam int VC_NUM_ENTRIES = 8;
    localparam int VC_BLOCK_BYTES = 64;
    localparam int VC_PAGE_OFF_W  = 12;
    localparam int VC_PTAG_W      = 44;

    // How the touched entry moves in recency order this cycle.
    typedef enum logic [1:0] {
        TOUCH_NONE = 2'd0,
        TOUCH_MRU  = 2'd1,
        TOUCH_LRU  = 2'd2
    } touch_e;

endpackage

// File: rtl/vc_lru.sv
// rtl/vc_lru.sv - age-counter replacement tracker for the victim cache
// Ports: clk, reset (sync, active-high), flush (re-initialise ages),
//        touch/touch_idx (move one entry to MRU or LRU),
//        lru_idx (entry currently holding the oldest age).
// Ages always form a permutation of 0..NUM_ENTRIES-1; 0 is most recent.
module vc_lru
    import vc_pkg::*;
#(
    parameter int NUM_ENTRIES = VC_NUM_ENTRIES,
    parameter int AGE_W       = $clog2(VC_NUM_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  touch_e           touch,
    input  logic [AGE_W-1:0] touch_idx,
    output logic [AGE_W-1:0] lru_idx
);

    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_ENTRIES - 1);

    logic [AGE_W-1:0] age_q [NUM_ENTRIES];
    logic [AGE_W-1:0] age_d [NUM_ENTRIES];
    logic [AGE_W-1:0] touch_age;

    always_comb begin
        touch_age = age_q[touch_idx];
        lru_idx   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            age_d[i] = age_q[i];
            if (age_q[i] == AGE_MAX) begin
                lru_idx = AGE_W'(i);
            end
            if (flush) begin
                age_d[i] = AGE_W'(i);
            end else if (touch == TOUCH_MRU) begin
                // Younger entries age by one so the permutation is preserved.
                if (AGE_W'(i) == touch_idx) begin
                    age_d[i] = '0;
                end else if (age_q[i] < touch_age) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end else if (touch == TOUCH_LRU) begin
                // Older entries get one step younger as the touched one leaves.
                if (AGE_W'(i) == touch_idx) begin
                    age_d[i] = AGE_MAX;
                end else if (age_q[i] > touch_age) begin
                    age_d[i] = age_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (reset) begin
                age_q[i] <= AGE_W'(i);
            end else begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: rtl/victim_cache_param.sv
// rtl/victim_cache_param.sv - fully associative victim cache beside L1
// Ports: clk, reset (sync, active-high); request req_valid/req_write/
//        page_offset/data_in; phys_tag_ret/tlb_miss one cycle after the
//        request; flush; response out_valid/is_found/byte_out/block_out/
//        evict_valid three edges after the request edge.
// Build option VC_EXCLUSIVE_EN: a read hit hands the block back to L1, so the
// entry is invalidated and made LRU instead of MRU.
module victim_cache_param
    import vc_pkg::*;
#(
    parameter int NUM_ENTRIES = VC_NUM_ENTRIES,
    parameter int BLOCK_BYTES = VC_BLOCK_BYTES,
    parameter int PAGE_OFF_W  = VC_PAGE_OFF_W,
    parameter int PTAG_W      = VC_PTAG_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic                     req_write,
    input  logic [PAGE_OFF_W-1:0]    page_offset,
    input  logic [BLOCK_BYTES*8-1:0] data_in,
    input  logic [PTAG_W-1:0]        phys_tag_ret,
    input  logic                     tlb_miss,
    input  logic                     flush,
    output logic                     out_valid,
    output logic                     is_found,
    output logic [7:0]               byte_out,
    output logic [BLOCK_BYTES*8-1:0] block_out,
    output logic                     evict_valid
);

    localparam int OFF_W      = $clog2(BLOCK_BYTES);
    localparam int VIDX_W     = PAGE_OFF_W - OFF_W;
    localparam int AGE_W      = $clog2(NUM_ENTRIES);
    localparam int BLOCK_BITS = BLOCK_BYTES * 8;

    typedef struct packed {
        logic [PTAG_W-1:0] ptag;
        logic [VIDX_W-1:0] vindex;
    } key_t;

    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic [OFF_W-1:0]      off;
        logic [VIDX_W-1:0]     vindex;
        logic [BLOCK_BITS-1:0] data;
    } tl_t;

    typedef struct packed {
        logic                  valid;
        logic                  found;
        logic                  evict;
        logic [7:0]            byte_val;
        logic [BLOCK_BITS-1:0] block;
    } rsp_t;

    tl_t  tl_q, tl_d;
    rsp_t tv_q, tv_d, dm_q, dm_d, out_q, out_d;

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    key_t                   key_q  [NUM_ENTRIES];
    key_t                   key_d  [NUM_ENTRIES];
    logic [BLOCK_BITS-1:0]  data_q [NUM_ENTRIES];
    logic [BLOCK_BITS-1:0]  data_d [NUM_ENTRIES];

    key_t                  tl_key;
    logic                  hit, have_inv;
    logic [AGE_W-1:0]      hit_idx, inv_idx, victim_idx, lru_idx, touch_idx;
    logic [BLOCK_BITS-1:0] hit_blk;
    touch_e                touch;

    vc_lru #(
        .NUM_ENTRIES(NUM_ENTRIES),
        .AGE_W      (AGE_W)
    ) u_lru (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .touch    (touch),
        .touch_idx(touch_idx),
        .lru_idx  (lru_idx)
    );

    always_comb begin
        tl_d.valid  = req_valid;
        tl_d.write  = req_write;
        tl_d.off    = page_offset[OFF_W-1:0];
        tl_d.vindex = page_offset[PAGE_OFF_W-1:OFF_W];
        tl_d.data   = data_in;

        tl_key.ptag   = phys_tag_ret;
        tl_key.vindex = tl_q.vindex;

        hit      = 1'b0;
        hit_idx  = '0;
        have_inv = 1'b0;
        inv_idx  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && key_q[i] == tl_key) begin
                hit     = 1'b1;
                hit_idx = AGE_W'(i);
            end
        end
        // Scan downwards so the lowest-index invalid entry wins.
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                have_inv = 1'b1;
                inv_idx  = AGE_W'(i);
            end
        end
        victim_idx = hit ? hit_idx : (have_inv ? inv_idx : lru_idx);
        hit_blk    = data_q[hit_idx];

        valid_d   = valid_q;
        key_d     = key_q;
        data_d    = data_q;
        touch     = TOUCH_NONE;
        touch_idx = victim_idx;
        tv_d       = '0;
        tv_d.valid = tl_q.valid;

        if (flush) begin
            // The TL request still answers, but as a plain miss.
            valid_d = '0;
        end else if (tl_q.valid && tl_q.write) begin
            if (!hit && !have_inv) begin
                tv_d.evict = 1'b1;
                tv_d.block = data_q[victim_idx];
            end
            valid_d[victim_idx] = 1'b1;
            key_d[victim_idx]   = tl_key;
            data_d[victim_idx]  = tl_q.data;
            touch               = TOUCH_MRU;
        end else if (tl_q.valid && !tlb_miss && hit) begin
            tv_d.found    = 1'b1;
            tv_d.block    = hit_blk;
            tv_d.byte_val = hit_blk[{tl_q.off, 3'b000} +: 8];
            touch_idx     = hit_idx;
`ifdef VC_EXCLUSIVE_EN
            valid_d[hit_idx] = 1'b0;
            touch            = TOUCH_LRU;
`else
            touch            = TOUCH_MRU;
`endif
        end

        dm_d  = tv_q;
        out_d = dm_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tl_q    <= '0;
            tv_q    <= '0;
            dm_q    <= '0;
            out_q   <= '0;
            valid_q <= '0;
        end else begin
            tl_q    <= tl_d;
            tv_q    <= tv_d;
            dm_q    <= dm_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    // Tag and data storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        key_q  <= key_d;
        data_q <= data_d;
    end

    assign out_valid   = out_q.valid;
    assign is_found    = out_q.found;
    assign evict_valid = out_q.evict;
    assign byte_out    = out_q.byte_val;
    assign block_out   = out_q.block;

endmodule

// File: tb/tb_victim_cache_param.sv
// tb/tb_victim_cache_param.sv - self-checking bench for victim_cache_param
module tb_victim_cache_param;

    localparam int NE   = 8;
    localparam int PTW  = 44;
    localparam int BITS = 512;
`ifdef VC_EXCLUSIVE_EN
    localparam bit EXCL = 1'b1;
`else
    localparam bit EXCL = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0, req_write = 1'b0, tlb_miss = 1'b0, flush = 1'b0;
    logic [11:0]     page_offset = '0;
    logic [BITS-1:0] data_in = '0;
    logic [PTW-1:0]  phys_tag_ret = '0;
    logic            out_valid, is_found, evict_valid;
    logic [7:0]      byte_out;
    logic [BITS-1:0] block_out;

    always #5 clk = ~clk;

    victim_cache_param dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .page_offset (page_offset),
        .data_in     (data_in),
        .phys_tag_ret(phys_tag_ret),
        .tlb_miss    (tlb_miss),
        .flush       (flush),
        .out_valid   (out_valid),
        .is_found    (is_found),
        .byte_out    (byte_out),
        .block_out   (block_out),
        .evict_valid (evict_valid)
    );

    typedef struct {
        int              due;
        logic            found;
        logic            evict;
        logic [7:0]      b;
        logic [BITS-1:0] blk;
    } exp_t;

    exp_t expq[$];
    exp_t cur;
    int   checks = 0;
    int   failures = 0;
    int   ecyc = 0;
    bit   chk_en = 1'b0;

    // Reference model: entry contents plus a recency list (front = MRU).
    logic            m_valid [NE];
    logic [PTW-1:0]  m_tag   [NE];
    logic [5:0]      m_vidx  [NE];
    logic [BITS-1:0] m_data  [NE];
    int              order[$];

    // Request sitting in the TL stage, with the tag/tlb_miss it will see.
    logic            p_valid = 1'b0, p_write = 1'b0, p_tm = 1'b0;
    logic [5:0]      p_off = '0, p_vidx = '0;
    logic [PTW-1:0]  p_tag = '0;
    logic [BITS-1:0] p_data = '0;

    always @(posedge clk) ecyc <= ecyc + 1;

    task automatic chk(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, ecyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (expq.size() > 0 && expq[0].due == ecyc) begin
                cur = expq.pop_front();
                chk("m_out_valid", out_valid, 1'b1);
                chk("m_is_found", is_found, cur.found);
                chk("m_byte_out", byte_out, cur.b);
                chk("m_evict_valid", evict_valid, cur.evict);
                chk("m_block_out", block_out, cur.blk);
            end else begin
                chk("m_idle_out_valid", out_valid, 1'b0);
            end
        end
    end

    function automatic void model_init();
        order.delete();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 1'b0;
            order.push_back(i);
        end
    endfunction

    function automatic void model_flush();
        model_init();
    endfunction

    function automatic void mv(input int idx, input bit front);
        for (int k = 0; k < order.size(); k++) begin
            if (order[k] == idx) begin
                order.delete(k);
                break;
            end
        end
        if (front) order.push_front(idx);
        else order.push_back(idx);
    endfunction

    task automatic model_tl(input logic fl);
        exp_t e;
        int   hit;
        int   vic;
        if (p_valid) begin
            e = '{due: ecyc + 3, found: 1'b0, evict: 1'b0, b: 8'h00, blk: '0};
            hit = -1;
            for (int i = 0; i < NE; i++)
                if (m_valid[i] && m_tag[i] == p_tag && m_vidx[i] == p_vidx) hit = i;
            if (fl) begin
                // flushed request: plain miss, no state change
            end else if (p_write) begin
                vic = hit;
                if (vic < 0) begin
                    for (int i = NE - 1; i >= 0; i--) if (!m_valid[i]) vic = i;
                    if (vic < 0) begin
                        vic     = order[$];
                        e.evict = 1'b1;
                        e.blk   = m_data[vic];
                    end
                end
                m_valid[vic] = 1'b1;
                m_tag[vic]   = p_tag;
                m_vidx[vic]  = p_vidx;
                m_data[vic]  = p_data;
                mv(vic, 1'b1);
            end else if (!p_tm && hit >= 0) begin
                e.found = 1'b1;
                e.blk   = m_data[hit];
                e.b     = m_data[hit][int'(p_off) * 8 +: 8];
                if (EXCL) begin
                    m_valid[hit] = 1'b0;
                    mv(hit, 1'b0);
                end else begin
                    mv(hit, 1'b1);
                end
            end
            expq.push_back(e);
        end
        if (fl) model_flush();
    endtask

    // One clock cycle: feed the TL-stage request its tag, present a new request.
    task automatic cyc(input logic v, input logic w, input logic [PTW-1:0] tag, input logic [5:0] vidx,
                       input logic [5:0] off, input logic [BITS-1:0] d, input logic tm, input logic fl);
        phys_tag_ret = p_tag;
        tlb_miss     = p_tm;
        flush        = fl;
        model_tl(fl);
        req_valid   = v;
        req_write   = w;
        page_offset = {vidx, off};
        data_in     = d;
        p_valid = v; p_write = w; p_tag = tag; p_vidx = vidx; p_off = off; p_data = d; p_tm = tm;
        @(negedge clk);
        #1;
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        chk_en    = 1'b0;
        reset     = 1'b1;
        req_valid = 1'b0;
        flush     = 1'b0;
        p_valid   = 1'b0;
        expq.delete();
        model_init();
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        reset  = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic lit(input string n, input logic f, input logic [7:0] b, input logic ev,
                       input logic [BITS-1:0] blk);
        chk({n, ".valid"}, out_valid, 1'b1);
        chk({n, ".found"}, is_found, f);
        chk({n, ".byte"}, byte_out, b);
        chk({n, ".evict"}, evict_valid, ev);
        chk({n, ".block"}, block_out, blk);
    endtask

    function automatic logic [BITS-1:0] kdata(input int i);
        return {16{32'hC0DE_0000 + i}};
    endfunction

    function automatic logic [BITS-1:0] rnd_blk();
        logic [BITS-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    logic [BITS-1:0] d0, d1, d2;
    logic            rv, rw, rtm, rfl;

    initial begin
        d0 = '0; d0[7:0] = 8'hAA; d0[79:72] = 8'h5C;
        d1 = '0; d1[7:0] = 8'h11;
        d2 = kdata(77); d2[39:32] = 8'h3E;
        model_init();
        do_reset();

        chk("reset.out_valid", out_valid, 1'b0);
        chk("reset.is_found", is_found, 1'b0);
        chk("reset.byte_out", byte_out, 8'h00);
        chk("reset.evict_valid", evict_valid, 1'b0);
        chk("reset.block_out", block_out, '0);

        cyc(1, 0, 44'hA, 6'd0, 6'd0, '0, 0, 0); bubble(3);
        lit("rd_cold", 1'b0, 8'h00, 1'b0, '0);
        cyc(1, 1, 44'hA, 6'd0, 6'd0, d0, 0, 0); bubble(3);
        lit("wr_first", 1'b0, 8'h00, 1'b0, '0);
        cyc(1, 0, 44'hA, 6'd0, 6'd0, '0, 0, 0); bubble(3);
        lit("rd_off0", 1'b1, 8'hAA, 1'b0, d0);
        cyc(1, 1, 44'hA, 6'd0, 6'd0, d0, 0, 0); bubble(3);
        lit("wr_again", 1'b0, 8'h00, 1'b0, '0);
        cyc(1, 0, 44'hA, 6'd0, 6'd9, '0, 0, 0); bubble(3);
        lit("rd_off9", 1'b1, 8'h5C, 1'b0, d0);
        cyc(1, 1, 44'hA, 6'd0, 6'd0, d1, 1, 0); bubble(3);
        lit("wr_dup", 1'b0, 8'h00, 1'b0, '0);
        cyc(1, 0, 44'hA, 6'd0, 6'd0, '0, 1, 0); bubble(3);
        lit("rd_tlbmiss", 1'b0, 8'h00, 1'b0, '0);
        cyc(1, 0, 44'hA, 6'd0, 6'd0, '0, 0, 0); bubble(3);
        lit("rd_new", 1'b1, 8'h11, 1'b0, d1);
        cyc(1, 0, 44'hA, 6'd0, 6'd0, '0, 0, 0); bubble(3);
        lit("rd_second", !EXCL, EXCL ? 8'h00 : 8'h11, 1'b0, EXCL ? '0 : d1);
        cyc(1, 1, 44'hA, 6'd0, 6'd0, d1, 0, 0); bubble(1);
        cyc(0, 0, '0, '0, '0, '0, 0, 1); bubble(2);
        cyc(1, 0, 44'hA, 6'd0, 6'd0, '0, 0, 0); bubble(3);
        lit("rd_after_flush", 1'b0, 8'h00, 1'b0, '0);

        cyc(1, 1, 44'hB, 6'd1, 6'd0, d2, 0, 0);
        cyc(1, 0, 44'hB, 6'd1, 6'd4, '0, 0, 0); bubble(2);
        lit("b2b_wr", 1'b0, 8'h00, 1'b0, '0);
        bubble(1);
        lit("b2b_rd", 1'b1, 8'h3E, 1'b0, d2);

        cyc(0, 0, '0, '0, '0, '0, 0, 1);
        for (int i = 0; i < 9; i++) cyc(1, 1, 44'h100 + 44'(i), 6'(i % 4), 6'd0, kdata(i), 0, 0);
        bubble(3);
        lit("ninth_wr", 1'b0, 8'h00, 1'b1, kdata(0));
        cyc(1, 0, 44'h100, 6'd0, 6'd0, '0, 0, 0); bubble(3);
        lit("rd_evicted", 1'b0, 8'h00, 1'b0, '0);

        cyc(0, 0, '0, '0, '0, '0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(1, 1, 44'h100 + 44'(i), 6'(i % 4), 6'd0, kdata(i), 0, 0);
        cyc(1, 0, 44'h100, 6'd0, 6'd0, '0, 0, 0);
        cyc(1, 1, 44'h108, 6'd0, 6'd0, kdata(8), 0, 0); bubble(3);
        lit("lru_after_touch", 1'b0, 8'h00, !EXCL, EXCL ? '0 : kdata(1));

        cyc(1, 1, 44'h200, 6'd2, 6'd0, kdata(9), 0, 0); bubble(1);
        do_reset();
        cyc(1, 0, 44'h200, 6'd2, 6'd0, '0, 0, 0); bubble(3);
        lit("rd_after_reset", 1'b0, 8'h00, 1'b0, '0);

        for (int n = 0; n < 800; n++) begin
            rv  = ($urandom_range(0, 9) < 8);
            rw  = $urandom_range(0, 1);
            rtm = ($urandom_range(0, 9) == 0);
            rfl = ($urandom_range(0, 49) == 0);
            if (n == 400) do_reset();
            cyc(rv, rw, 44'($urandom_range(0, 5)), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                rnd_blk(), rtm, rfl);
        end
        bubble(5);
        chk("drain_empty", 32'(expq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
